adder_subractor: RTL and testbench
==================================

# adder_subractor

64-bit two's-complement adder/subtractor with signed-overflow detection and a registered result. It is the arithmetic core behind the pipeline ALU's add and subtract operations. A mode bit selects the operation. Result and overflow flag are captured on the clock edge following the operands.

## Interface
- Parameters: none (width fixed at 64).
- `clk`  input  1  single system clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in1`  input  64  operand A (two's complement).
- `in2`  input  64  operand B (two's complement).
- `M`  input  1  mode: 0 = add (A+B), 1 = subtract (A−B).
- `out`  output  64  registered result, low 64 bits of the operation.
- `overflow`  output  1  registered signed-overflow flag for `out`.

## Operation
- Datapath is 64 full-adder slices in a ripple-carry chain, built by a generate loop.
  - Each slice computes `s = a ^ b ^ c`, `co = a&b | c&(a^b)`.
- B-operand conditioning: slice i receives `in2[i] ^ M`.
- Carry-in to slice 0 is `M`, so subtract is A + ~B + 1.
- Raw sum: bits 0..63 of the chain; the final carry-out is discarded from the result.
- Overflow rule: `ov = c63 ^ c64`, i.e. carry into bit 63 XOR carry out of bit 63.
  - Add: overflow when same-sign operands give an opposite-sign result.
  - Subtract: overflow when opposite-sign operands give a result whose sign differs from A.
- Unsigned carry/borrow is not exported.
- No saturation; `out` always wraps modulo 2^64.
- Inputs are sampled every cycle with no enable or valid handshake. Every rising edge loads a new result.

## Timing
- Combinational path: in1/in2/M → 64-slice ripple → output registers. This is a single-cycle path with no internal pipelining.
- Latency: 1 cycle. Operands stable before rising edge N appear on `out`/`overflow` after edge N and hold until edge N+1.
- Throughput: one operation per cycle.
- Reset: while `rst_n` = 0, `out` = 64'h0 and `overflow` = 0 immediately, independent of `clk`.
- Release of reset: the first rising edge with `rst_n` = 1 loads the current operands.
- Reset asserted mid-operation: the pending result is discarded. Outputs clear at once and no stale value appears after release.
- Changing `M` or operands between edges has no effect on outputs until the next rising edge. No glitches reach the outputs.

## Test plan
- Add: in1=11, in2=3, M=0, one edge → out=14, overflow=0.
- Subtract equal: in1=64, in2=64, M=1, one edge → out=0, overflow=0.
- Positive overflow: in1=64'h7FFF_FFFF_FFFF_FFFF, in2=1, M=0 → out=64'h8000_0000_0000_0000, overflow=1.
- Negative overflow on subtract: in1=64'h8000_0000_0000_0000, in2=1, M=1 → out=64'h7FFF_FFFF_FFFF_FFFF, overflow=1.
- Wrap without overflow: in1=0, in2=1, M=1 → out=64'hFFFF_FFFF_FFFF_FFFF, overflow=0.
  - Then in1=all-ones, in2=1, M=0 → out=0, overflow=0.
- Reset: load in1=11, in2=3, M=0, clock once so out=14.
  - Assert `rst_n`=0 between edges → out=0 and overflow=0 immediately.
  - Hold reset over two edges → outputs stay 0.
  - Release → next edge gives out=14.

Source files
------------

// File: rtl/adder_subractor.sv
// adder_subractor: 64-bit two's-complement adder/subtractor with a
// registered result and signed-overflow flag.
//   clk      - system clock, rising-edge active
//   rst_n    - asynchronous active-low reset, clears out/overflow
//   in1      - operand A
//   in2      - operand B
//   M        - mode: 0 = A+B, 1 = A-B
//   out      - registered low 64 bits of the result
//   overflow - registered signed-overflow flag for out

// One full-adder slice of the ripple chain.
//   a, b, c - addend bits and carry-in
//   s, co   - sum bit and carry-out
module fa_slice (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ c;
  assign co = (a & b) | (c & (a ^ b));
endmodule

module adder_subractor (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] in1,
  input  logic [63:0] in2,
  input  logic        M,
  output logic [63:0] out,
  output logic        overflow
);
  localparam int W = 64;

  typedef struct packed {
    logic [W-1:0] res;
    logic         ov;
  } rsp_t;

  logic [W:0]   carry;
  logic [W-1:0] sum;
  rsp_t         rsp;

  // Subtract is A + ~B + 1: invert B per slice and inject M as carry-in.
  assign carry[0] = M;

  for (genvar i = 0; i < W; i++) begin : g_slice
    fa_slice u_fa (
      .a  (in1[i]),
      .b  (in2[i] ^ M),
      .c  (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  // Signed overflow: carry into the sign bit disagrees with carry out of it.
  // carry[W] itself is dropped; unsigned carry/borrow is not exported.
  assign rsp.res = sum;
  assign rsp.ov  = carry[W-1] ^ carry[W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out      <= '0;
      overflow <= 1'b0;
    end else begin
      out      <= rsp.res;
      overflow <= rsp.ov;
    end
  end
endmodule

// File: tb/tb_adder_subractor.sv
// Scoreboard bench for adder_subractor: stimulus pushes the expected
// registered response before each rising edge; the monitor pops and
// compares one entry after every edge that has one pending.
module tb_adder_subractor;
  logic        clk;
  logic        rst_n;
  logic [63:0] in1, in2;
  logic        M;
  logic [63:0] out;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [63:0] res;
    logic        ov;
  } exp_t;

  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] b;
    logic        m;
    logic [63:0] res;
    logic        ov;
  } vec_t;

  exp_t q[$];
  exp_t mon_e;
  vec_t vecs[$];

  adder_subractor dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in1      (in1),
    .in2      (in2),
    .M        (M),
    .out      (out),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare after each rising edge that has an expectation queued.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        checks++;
        if (out !== mon_e.res || overflow !== mon_e.ov) begin
          errors++;
          $display("FAIL %s: got out=%h ov=%b, expected out=%h ov=%b",
                   mon_e.name, out, overflow, mon_e.res, mon_e.ov);
        end
      end
    end
  end

  task automatic check_now(input string name, input logic [63:0] r, input logic o);
    checks++;
    if (out !== r || overflow !== o) begin
      errors++;
      $display("FAIL %s: got out=%h ov=%b, expected out=%h ov=%b",
               name, out, overflow, r, o);
    end
  endtask

  task automatic drive(input vec_t v);
    exp_t e;
    in1 = v.a;
    in2 = v.b;
    M   = v.m;
    e.name = v.name;
    e.res  = v.res;
    e.ov   = v.ov;
    q.push_back(e);
  endtask

  task automatic push_exp(input string name, input logic [63:0] r, input logic o);
    exp_t e;
    e.name = name;
    e.res  = r;
    e.ov   = o;
    q.push_back(e);
  endtask

  initial begin
    // Hand-computed vectors: name, A, B, M, expected out, expected overflow.
    vecs.push_back('{"add_11_3",    64'd11, 64'd3, 1'b0, 64'd14, 1'b0});
    vecs.push_back('{"sub_eq",      64'd64, 64'd64, 1'b1, 64'd0, 1'b0});
    vecs.push_back('{"pos_ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
                     64'h8000_0000_0000_0000, 1'b1});
    vecs.push_back('{"neg_ovf_sub", 64'h8000_0000_0000_0000, 64'd1, 1'b1,
                     64'h7FFF_FFFF_FFFF_FFFF, 1'b1});
    vecs.push_back('{"wrap_sub",    64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
    vecs.push_back('{"wrap_add",    64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b0});
    vecs.push_back('{"neg5_plus3",  64'hFFFF_FFFF_FFFF_FFFB, 64'd3, 1'b0,
                     64'hFFFF_FFFF_FFFF_FFFE, 1'b0});
    vecs.push_back('{"5_minus7",    64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0});
    vecs.push_back('{"min_plus_min", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
                     64'd0, 1'b1});
    vecs.push_back('{"max_minus_neg1", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                     64'h8000_0000_0000_0000, 1'b1});
    vecs.push_back('{"min_minus_min", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,
                     64'd0, 1'b0});
    vecs.push_back('{"zero_minus_min", 64'd0, 64'h8000_0000_0000_0000, 1'b1,
                     64'h8000_0000_0000_0000, 1'b1});
    vecs.push_back('{"neg1_plus_neg1", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                     64'hFFFF_FFFF_FFFF_FFFE, 1'b0});
    vecs.push_back('{"alt_bits_add", 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0,
                     64'hFFFF_FFFF_FFFF_FFFF, 1'b0});

    // Power-on reset with live operands: outputs must stay clear.
    rst_n = 1'b0;
    in1   = 64'd11;
    in2   = 64'd3;
    M     = 1'b0;
    #3;
    check_now("reset_initial", 64'd0, 1'b0);
    @(negedge clk);
    push_exp("reset_hold_init", 64'd0, 1'b0);
    @(posedge clk);

    // First edge after release loads the current operands.
    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge clk);
      @(negedge clk);
    end

    // Mid-stream reset: load 11+3, then reset between edges.
    drive('{"pre_reset_load", 64'd11, 64'd3, 1'b0, 64'd14, 1'b0});
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_now("reset_async_clear", 64'd0, 1'b0);
    push_exp("reset_hold_edge1", 64'd0, 1'b0);
    push_exp("reset_hold_edge2", 64'd0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push_exp("post_reset_reload", 64'd14, 1'b0);
    @(posedge clk);

    // Operand changes between edges must not reach the outputs.
    @(negedge clk);
    in1 = 64'd100;
    in2 = 64'd1;
    M   = 1'b1;
    #2;
    check_now("hold_between_edges", 64'd14, 1'b0);
    push_exp("after_hold_edge", 64'd99, 1'b0);
    @(posedge clk);

    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end
endmodule
